// File: rtl/apb_rr_master_arb.sv
// Round-robin arbiter sharing one APB master port among NREQ requesters.
// Grants one requester, latches its command and runs SETUP/ACCESS on APB.
module apb_rr_master_arb #(
  parameter int NREQ    = 4,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             preset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic             err,
  output logic [DW-1:0]    rdata,
  output logic             psel,
  output logic             penable,
  output logic             pwrite,
  output logic [AW-1:0]    paddress,
  output logic [DW-1:0]    pwdata,
  input  logic             pready,
  input  logic [DW-1:0]    pread
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   win_q;
  logic [PW-1:0]   win_d;
  logic            found;
  logic [CW-1:0]   cnt_q;
  logic            to_hit;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic            err_q;
  logic [DW-1:0]   rdata_q;
  logic            psel_q;
  logic            penable_q;
  logic            pwrite_q;
  logic [AW-1:0]   paddr_q;
  logic [DW-1:0]   pwdata_q;

  // First requesting index at or after the pointer, wrapping.
  always_comb begin
    win_d = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[(int'(ptr_q) + i) % NREQ]) begin
        found = 1'b1;
        win_d = PW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  assign to_hit = (TIMEOUT != 0) &&
                  (int'(cnt_q) + 1 >= TIMEOUT);

  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            win_q    <= win_d;
            gnt_q    <= NREQ'(1) << win_d;
            pwrite_q <= req_write[win_d];
            paddr_q  <= req_addr[int'(win_d)*AW +: AW];
            pwdata_q <= req_write[win_d] ?
                        req_wdata[int'(win_d)*DW +: DW] : '0;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            done_q    <= gnt_q;
            if (!pwrite_q) rdata_q <= pread;
            state_q   <= DONE;
          end else begin
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            if (to_hit) begin
              psel_q    <= 1'b0;
              penable_q <= 1'b0;
              done_q    <= gnt_q;
              err_q     <= 1'b1;
              state_q   <= DONE;
            end
          end
        end
        DONE: begin
          done_q   <= '0;
          err_q    <= 1'b0;
          rdata_q  <= '0;
          gnt_q    <= '0;
          pwdata_q <= '0;
          ptr_q    <= (int'(win_q) == NREQ - 1) ?
                      '0 : win_q + 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign psel     = psel_q;
  assign penable  = penable_q;
  assign pwrite   = pwrite_q;
  assign paddress = paddr_q;
  assign pwdata   = pwdata_q;

endmodule

// File: tb/tb_apb_rr_master_arb.sv
// Bench for apb_rr_master_arb: directed scenarios then randomized
// transfers, checked against a transaction-level reference model.
module tb_apb_rr_master_arb;

  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int TO   = 16;

  logic            clk = 1'b0;
  logic            preset;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] req_write;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic            err;
  logic [7:0]      rdata;
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [7:0]      paddress;
  logic [7:0]      pwdata;
  logic            pready;
  logic [7:0]      pread;

  int n_chk  = 0;
  int n_fail = 0;
  int m_ptr  = 0;

  apb_rr_master_arb #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .preset(preset),
    .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddress(paddress), .pwdata(pwdata),
    .pready(pready), .pread(pread)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: first pending requester from the pointer, wrapping.
  function automatic int pick(input logic [NREQ-1:0] r,
                              input int p);
    for (int i = 0; i < NREQ; i++)
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_rdata"}, 32'(rdata), 0);
    chk({tag, "_psel"}, 32'(psel), 0);
    chk({tag, "_penable"}, 32'(penable), 0);
    chk({tag, "_pwrite"}, 32'(pwrite), 0);
    chk({tag, "_paddr"}, 32'(paddress), 0);
    chk({tag, "_pwdata"}, 32'(pwdata), 0);
  endtask

  // One full transfer starting from IDLE with req pending.
  // wait_n = ACCESS cycles with pready low before it rises.
  task automatic xfer(input int wait_n, input bit scramble,
                      input logic [7:0] rv);
    int w;
    int len;
    bit ew;
    bit eerr;
    logic [7:0] ea;
    logic [7:0] ed;
    w = pick(req, m_ptr);
    if (w < 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL no_pending observed=0 expected=1");
      return;
    end
    ew   = req_write[w];
    ea   = req_addr[w*8 +: 8];
    ed   = req_wdata[w*8 +: 8];
    eerr = (TO != 0) && (wait_n >= TO);
    len  = eerr ? TO : wait_n + 1;
    step();
    chk("setup_gnt", 32'(gnt), 32'(1) << w);
    chk("setup_psel", 32'(psel), 1);
    chk("setup_pen", 32'(penable), 0);
    chk("setup_addr", 32'(paddress), 32'(ea));
    chk("setup_wr", 32'(pwrite), 32'(ew));
    chk("setup_wdata", 32'(pwdata), ew ? 32'(ed) : 0);
    if (scramble) begin
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_write = 4'($urandom);
    end
    step();
    for (int k = 0; k < len; k++) begin
      chk("acc_psel", 32'(psel), 1);
      chk("acc_pen", 32'(penable), 1);
      chk("acc_addr", 32'(paddress), 32'(ea));
      chk("acc_wr", 32'(pwrite), 32'(ew));
      chk("acc_done", 32'(done), 0);
      pready = (k >= wait_n);
      pread  = (k >= wait_n) ? rv : 8'($urandom);
      step();
    end
    pready = 1'b0;
    chk("done_pulse", 32'(done), 32'(1) << w);
    chk("done_gnt", 32'(gnt), 32'(1) << w);
    chk("done_err", 32'(err), 32'(eerr));
    chk("done_rdata", 32'(rdata),
        (!ew && !eerr) ? 32'(rv) : 0);
    chk("done_psel", 32'(psel), 0);
    chk("done_pen", 32'(penable), 0);
    req[w] = 1'b0;
    m_ptr  = (w + 1) % NREQ;
    step();
    chk("idle_gnt", 32'(gnt), 0);
    chk("idle_done", 32'(done), 0);
    chk("idle_psel", 32'(psel), 0);
    chk("idle_addr", 32'(paddress), 32'(ea));
    chk("idle_wr", 32'(pwrite), 32'(ew));
    chk("idle_wdata", 32'(pwdata), 0);
  endtask

  task automatic do_reset();
    preset = 1'b1;
    step();
    step();
    chk_zero("rst");
    preset = 1'b0;
    m_ptr  = 0;
  endtask

  initial begin
    preset    = 1'b1;
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    pready    = 1'b0;
    pread     = '0;
    do_reset();

    // Single write from requester 0, zero wait states.
    req_write = 4'b0001;
    req_addr  = 32'h0000_0012;
    req_wdata = 32'h0000_00A5;
    req       = 4'b0001;
    xfer(0, 1'b0, 8'h00);

    // Read from requester 2 with three wait states.
    req_write = 4'b0000;
    req_addr  = 32'h0040_0000;
    req       = 4'b0100;
    xfer(3, 1'b1, 8'h3C);

    // Timeout on requester 3, then requester 0 served.
    req_write = 4'b0000;
    req       = 4'b1001;
    xfer(40, 1'b0, 8'($urandom));
    xfer(0, 1'b0, 8'($urandom));

    // Move pointer to 2, then abort a transfer with reset.
    req = 4'b0010;
    xfer(1, 1'b0, 8'($urandom));
    req = 4'b0100;
    step();
    step();
    pready = 1'b0;
    #2 preset = 1'b1;
    #1;
    chk_zero("abort");
    req = 4'b1010;
    step();
    chk_zero("abort_hold");
    preset = 1'b0;
    m_ptr  = 0;
    xfer(0, 1'b0, 8'($urandom));

    // All four requesting together from pointer 0, then wrap.
    do_reset();
    req_write = 4'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req       = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      chk("rr_order", 32'(pick(req, m_ptr)), 32'(i));
      xfer(i, 1'b1, 8'($urandom));
    end
    chk("rr_wrap_ptr", 32'(m_ptr), 0);
    req = 4'b0011;
    xfer(0, 1'b0, 8'($urandom));
    chk("rr_wrap_win", 32'(m_ptr), 1);

    // Randomized traffic; pending requests accumulate.
    for (int n = 0; n < 40; n++) begin
      int wt;
      req = req | 4'($urandom);
      if (req == '0) req = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) begin
        req_write = 4'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
      end
      wt = ($urandom_range(0, 9) == 0) ?
           int'($urandom_range(16, 20)) :
           int'($urandom_range(0, 3));
      xfer(wt, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
